// File: rtl/dsp_macc_pkg.sv
// ============================================================================
// Module : dsp_macc_pkg
// Brief  : Shared mode encodings and the saturating-add helper for dsp_macc_nch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dsp_macc_pkg;

  typedef enum logic [1:0] {
    INM_A   = 2'b00,
    INM_DPA = 2'b01,
    INM_DMA = 2'b10,
    INM_D   = 2'b11
  } inmode_e;

  typedef enum logic [1:0] {
    ACC_LOAD = 2'b00,
    ACC_ADD  = 2'b01,
    ACC_SUB  = 2'b10,
    ACC_CLR  = 2'b11
  } accmode_e;

  localparam int SAT_MAX_W = 128;

  // sum_i carries a (pw_i+1)-bit signed value sign-extended to SAT_MAX_W+1 bits;
  // the result is clamped to the signed range of pw_i bits.
  function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W:0] sum_i,
                                                   input logic [7:0]         pw_i);
    logic                 sgn;
    logic                 top;
    logic [SAT_MAX_W-1:0] res;
    sgn = sum_i[pw_i];
    top = sum_i[pw_i - 8'd1];
    res = sum_i[SAT_MAX_W-1:0];
    if (sgn != top) begin
      for (int i = 0; i < SAT_MAX_W; i++) begin
        res[i] = (i < int'(pw_i) - 1) ? ~sgn : sgn;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_preadd_mult.sv
// ============================================================================
// Module : dsp_preadd_mult
// Brief  : Input registers, signed pre-adder and multiplier with optional
//          MREG stage; channel/mode/addend sideband travels with the data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dsp_preadd_mult
  import dsp_macc_pkg::*;
#(
  parameter  int A_W  = 25,
  parameter  int B_W  = 18,
  parameter  int D_W  = 25,
  parameter  int P_W  = 48,
  parameter  int CH_W = 2,
  parameter  int MREG = 1,
  localparam int AD_W = ((A_W > D_W) ? A_W : D_W) + 1,
  localparam int M_W  = AD_W + B_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [CH_W-1:0]        ch_i,
  input  logic [A_W-1:0]         a_i,
  input  logic [D_W-1:0]         d_i,
  input  logic [B_W-1:0]         b_i,
  input  logic [P_W-1:0]         c_i,
  input  logic [1:0]             inmode_i,
  input  logic [1:0]             accmode_i,
  output logic                   valid_o,
  output logic [CH_W-1:0]        ch_o,
  output logic signed [P_W-1:0]  c_o,
  output logic [1:0]             accmode_o,
  output logic signed [M_W-1:0]  m_o
);

  logic                  s1_valid_q;
  logic [CH_W-1:0]       s1_ch_q;
  logic signed [A_W-1:0] s1_a_q;
  logic signed [D_W-1:0] s1_d_q;
  logic signed [B_W-1:0] s1_b_q;
  logic signed [P_W-1:0] s1_c_q;
  logic [1:0]            s1_inmode_q;
  logic [1:0]            s1_accmode_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_ch_q      <= '0;
      s1_a_q       <= '0;
      s1_d_q       <= '0;
      s1_b_q       <= '0;
      s1_c_q       <= '0;
      s1_inmode_q  <= '0;
      s1_accmode_q <= '0;
    end else begin
      s1_valid_q   <= valid_i;
      s1_ch_q      <= ch_i;
      s1_a_q       <= a_i;
      s1_d_q       <= d_i;
      s1_b_q       <= b_i;
      s1_c_q       <= c_i;
      s1_inmode_q  <= inmode_i;
      s1_accmode_q <= accmode_i;
    end
  end

  logic signed [AD_W-1:0] a_ext;
  logic signed [AD_W-1:0] d_ext;
  logic signed [AD_W-1:0] ad_d;

  assign a_ext = AD_W'(s1_a_q);
  assign d_ext = AD_W'(s1_d_q);

  always_comb begin
    ad_d = a_ext;
    case (inmode_e'(s1_inmode_q))
      INM_A:   ad_d = a_ext;
      INM_DPA: ad_d = d_ext + a_ext;
      INM_DMA: ad_d = d_ext - a_ext;
      INM_D:   ad_d = d_ext;
      default: ad_d = a_ext;
    endcase
  end

  logic                   s2_valid_q;
  logic [CH_W-1:0]        s2_ch_q;
  logic signed [AD_W-1:0] s2_ad_q;
  logic signed [B_W-1:0]  s2_b_q;
  logic signed [P_W-1:0]  s2_c_q;
  logic [1:0]             s2_accmode_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_q   <= 1'b0;
      s2_ch_q      <= '0;
      s2_ad_q      <= '0;
      s2_b_q       <= '0;
      s2_c_q       <= '0;
      s2_accmode_q <= '0;
    end else begin
      s2_valid_q   <= s1_valid_q;
      s2_ch_q      <= s1_ch_q;
      s2_ad_q      <= ad_d;
      s2_b_q       <= s1_b_q;
      s2_c_q       <= s1_c_q;
      s2_accmode_q <= s1_accmode_q;
    end
  end

  // Both operands widened to the full product width so the multiply is exact.
  logic signed [M_W-1:0] prod_d;
  assign prod_d = M_W'(s2_ad_q) * M_W'(s2_b_q);

  logic                  mp_valid;
  logic [CH_W-1:0]       mp_ch;
  logic signed [P_W-1:0] mp_c;
  logic [1:0]            mp_accmode;
  logic signed [M_W-1:0] mp_m;

  generate
    if (MREG != 0) begin : g_mreg
      logic                  mreg_valid_q;
      logic [CH_W-1:0]       mreg_ch_q;
      logic signed [P_W-1:0] mreg_c_q;
      logic [1:0]            mreg_accmode_q;
      logic signed [M_W-1:0] mreg_m_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          mreg_valid_q   <= 1'b0;
          mreg_ch_q      <= '0;
          mreg_c_q       <= '0;
          mreg_accmode_q <= '0;
          mreg_m_q       <= '0;
        end else begin
          mreg_valid_q   <= s2_valid_q;
          mreg_ch_q      <= s2_ch_q;
          mreg_c_q       <= s2_c_q;
          mreg_accmode_q <= s2_accmode_q;
          mreg_m_q       <= prod_d;
        end
      end

      assign mp_valid   = mreg_valid_q;
      assign mp_ch      = mreg_ch_q;
      assign mp_c       = mreg_c_q;
      assign mp_accmode = mreg_accmode_q;
      assign mp_m       = mreg_m_q;
    end else begin : g_no_mreg
      assign mp_valid   = s2_valid_q;
      assign mp_ch      = s2_ch_q;
      assign mp_c       = s2_c_q;
      assign mp_accmode = s2_accmode_q;
      assign mp_m       = prod_d;
    end
  endgenerate

  logic                  s3_valid_q;
  logic [CH_W-1:0]       s3_ch_q;
  logic signed [P_W-1:0] s3_c_q;
  logic [1:0]            s3_accmode_q;
  logic signed [M_W-1:0] s3_m_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s3_valid_q   <= 1'b0;
      s3_ch_q      <= '0;
      s3_c_q       <= '0;
      s3_accmode_q <= '0;
      s3_m_q       <= '0;
    end else begin
      s3_valid_q   <= mp_valid;
      s3_ch_q      <= mp_ch;
      s3_c_q       <= mp_c;
      s3_accmode_q <= mp_accmode;
      s3_m_q       <= mp_m;
    end
  end

  assign valid_o   = s3_valid_q;
  assign ch_o      = s3_ch_q;
  assign c_o       = s3_c_q;
  assign accmode_o = s3_accmode_q;
  assign m_o       = s3_m_q;

endmodule

`default_nettype wire

// File: rtl/dsp_macc_nch.sv
// ============================================================================
// Module : dsp_macc_nch
// Brief  : Multi-channel pre-add/multiply-accumulate slice with a bank of NCH
//          accumulators, pattern-detect autoreset and overflow flags.
//          Define DSP_MACC_SAT_EN to clamp overflowing results instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dsp_macc_nch
  import dsp_macc_pkg::*;
#(
  parameter  int             A_W       = 25,
  parameter  int             B_W       = 18,
  parameter  int             D_W       = 25,
  parameter  int             P_W       = 48,
  parameter  int             NCH       = 4,
  parameter  int             MREG      = 1,
  parameter  logic [P_W-1:0] PATTERN   = '0,
  parameter  logic [P_W-1:0] MASK      = '1,
  parameter  int             AUTORESET = 0,
  localparam int             CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  input  logic [CH_W-1:0]       CH,
  input  logic [A_W-1:0]        A,
  input  logic [D_W-1:0]        D,
  input  logic [B_W-1:0]        B,
  input  logic [P_W-1:0]        C,
  input  logic [1:0]            INMODE,
  input  logic [1:0]            ACCMODE,
  input  logic                  CLR_ALL,
  output logic                  OUT_VALID,
  output logic [CH_W-1:0]       OUT_CH,
  output logic [P_W-1:0]        P,
  output logic                  PATTERNDETECT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int AD_W = ((A_W > D_W) ? A_W : D_W) + 1;
  localparam int M_W  = AD_W + B_W;

  generate
    if (P_W < M_W) begin : g_width_chk
      $error("dsp_macc_nch: P_W must be >= AD_W+B_W");
    end
`ifdef DSP_MACC_SAT_EN
    if (P_W > SAT_MAX_W) begin : g_sat_width_chk
      $error("dsp_macc_nch: P_W exceeds saturation helper width");
    end
`endif
  endgenerate

  logic                  s3_valid;
  logic [CH_W-1:0]       s3_ch;
  logic signed [P_W-1:0] s3_c;
  logic [1:0]            s3_accmode;
  logic signed [M_W-1:0] s3_m;

  dsp_preadd_mult #(
    .A_W  (A_W),
    .B_W  (B_W),
    .D_W  (D_W),
    .P_W  (P_W),
    .CH_W (CH_W),
    .MREG (MREG)
  ) u_preadd_mult (
    .clk_i     (CLK),
    .rst_i     (RST),
    .valid_i   (IN_VALID),
    .ch_i      (CH),
    .a_i       (A),
    .d_i       (D),
    .b_i       (B),
    .c_i       (C),
    .inmode_i  (INMODE),
    .accmode_i (ACCMODE),
    .valid_o   (s3_valid),
    .ch_o      (s3_ch),
    .c_o       (s3_c),
    .accmode_o (s3_accmode),
    .m_o       (s3_m)
  );

  logic ch_ok;
  logic take;

  generate
    if (NCH == (2 ** CH_W)) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_range
      assign ch_ok = ({1'b0, s3_ch} < (CH_W+1)'(NCH));
    end
  endgenerate

  // Out-of-range channels turn into bubbles here, before any bank access.
  assign take = s3_valid & ch_ok;

  logic signed [P_W-1:0] bank_q [NCH];
  logic signed [P_W-1:0] acc_rd;

  always_comb begin
    acc_rd = '0;
    for (int k = 0; k < NCH; k++) begin
      if (s3_ch == CH_W'(k)) acc_rd = bank_q[k];
    end
  end

  logic signed [P_W:0] m_ext;
  logic signed [P_W:0] sum_d;

  assign m_ext = (P_W+1)'(s3_m);

  always_comb begin
    sum_d = '0;
    case (accmode_e'(s3_accmode))
      ACC_LOAD: sum_d = m_ext + (P_W+1)'(s3_c);
      ACC_ADD:  sum_d = (P_W+1)'(acc_rd) + m_ext;
      ACC_SUB:  sum_d = (P_W+1)'(acc_rd) - m_ext;
      ACC_CLR:  sum_d = '0;
      default:  sum_d = '0;
    endcase
  end

  logic                  ovf_d;
  logic                  unf_d;
  logic signed [P_W-1:0] res_d;
  logic                  pd_d;
  logic signed [P_W-1:0] store_d;

  assign ovf_d = ~sum_d[P_W] &  sum_d[P_W-1];
  assign unf_d =  sum_d[P_W] & ~sum_d[P_W-1];

`ifdef DSP_MACC_SAT_EN
  assign res_d = P_W'(sat_add((SAT_MAX_W+1)'(sum_d), 8'(P_W)));
`else
  assign res_d = sum_d[P_W-1:0];
`endif

  assign pd_d    = (((res_d ^ PATTERN) & ~MASK) == '0);
  assign store_d = ((AUTORESET != 0) && pd_d) ? '0 : res_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NCH; k++) bank_q[k] <= '0;
    end else if (CLR_ALL) begin
      for (int k = 0; k < NCH; k++) bank_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (take && (s3_ch == CH_W'(k))) bank_q[k] <= store_d;
      end
    end
  end

  logic                  out_valid_q;
  logic [CH_W-1:0]       out_ch_q;
  logic signed [P_W-1:0] p_q;
  logic                  pd_q;
  logic                  ovf_q;
  logic                  unf_q;

  // Result and channel hold between samples; the flags only live for one pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      p_q         <= '0;
      pd_q        <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      out_valid_q <= take;
      if (take) begin
        out_ch_q <= s3_ch;
        p_q      <= res_d;
        pd_q     <= pd_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end else begin
        pd_q     <= 1'b0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end
    end
  end

  assign OUT_VALID     = out_valid_q;
  assign OUT_CH        = out_ch_q;
  assign P             = p_q;
  assign PATTERNDETECT = pd_q;
  assign OVERFLOW      = ovf_q;
  assign UNDERFLOW     = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_macc_nch.sv
// ============================================================================
// Module : tb_dsp_macc_nch
// Brief  : Scoreboard bench for dsp_macc_nch (NCH=4, MREG=1, P_W=48,
//          AUTORESET=1, PATTERN=100, MASK=0); honours DSP_MACC_SAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dsp_macc_nch;

  localparam logic signed [47:0] MAXP = 48'sh7FFF_FFFF_FFFF;
  localparam logic signed [47:0] MINP = 48'sh8000_0000_0000;
`ifdef DSP_MACC_SAT_EN
  localparam logic signed [47:0] OV_P = MAXP;
  localparam logic signed [47:0] UF_P = MINP;
`else
  localparam logic signed [47:0] OV_P = MINP;
  localparam logic signed [47:0] UF_P = MAXP;
`endif

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               IN_VALID = 1'b0;
  logic               CLR_ALL = 1'b0;
  logic [1:0]         CH = '0;
  logic [1:0]         INMODE = '0;
  logic [1:0]         ACCMODE = '0;
  logic signed [24:0] A = '0;
  logic signed [24:0] D = '0;
  logic signed [17:0] B = '0;
  logic signed [47:0] C = '0;
  logic               OUT_VALID;
  logic [1:0]         OUT_CH;
  logic signed [47:0] P;
  logic               PATTERNDETECT;
  logic               OVERFLOW;
  logic               UNDERFLOW;

  dsp_macc_nch #(
    .A_W(25), .B_W(18), .D_W(25), .P_W(48), .NCH(4), .MREG(1),
    .PATTERN(48'd100), .MASK(48'd0), .AUTORESET(1)
  ) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .CH(CH), .A(A), .D(D), .B(B), .C(C),
    .INMODE(INMODE), .ACCMODE(ACCMODE), .CLR_ALL(CLR_ALL), .OUT_VALID(OUT_VALID),
    .OUT_CH(OUT_CH), .P(P), .PATTERNDETECT(PATTERNDETECT), .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic signed [47:0] p;
    logic [1:0]         ch;
    logic               pd;
    logic               ov;
    logic               uf;
    int                 cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (OUT_VALID) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: got P=0x%0h ch=%0d expected no output", P, OUT_CH);
        end else begin
          mon_e = sbq.pop_front();
          check("P", P, mon_e.p);
          check("OUT_CH", OUT_CH, mon_e.ch);
          check("PATTERNDETECT", PATTERNDETECT, mon_e.pd);
          check("OVERFLOW", OVERFLOW, mon_e.ov);
          check("UNDERFLOW", UNDERFLOW, mon_e.uf);
          check("latency_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("idle_flags", {PATTERNDETECT, OVERFLOW, UNDERFLOW}, 3'b000);
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] ch, input logic [1:0] im,
                       input logic signed [24:0] a, input logic signed [24:0] d,
                       input logic signed [17:0] b, input logic signed [47:0] c,
                       input logic [1:0] am, input logic clr);
    @(posedge CLK);
    #1;
    IN_VALID = v; CH = ch; INMODE = im; A = a; D = d; B = b; C = c;
    ACCMODE = am; CLR_ALL = clr;
  endtask

  task automatic idle(input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'($urandom), 2'($urandom), 25'($urandom), 25'($urandom),
            18'($urandom), 48'({$urandom, $urandom}), 2'($urandom), clr);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [1:0] im,
                      input logic signed [24:0] a, input logic signed [24:0] d,
                      input logic signed [17:0] b, input logic signed [47:0] c,
                      input logic [1:0] am, input logic signed [47:0] ep,
                      input logic epd, input logic eov, input logic euf);
    exp_t e;
    drive(1'b1, ch, im, a, d, b, c, am, 1'b0);
    e.p = ep; e.ch = ch; e.pd = epd; e.ov = eov; e.uf = euf;
    e.cyc = cyc + 5;
    sbq.push_back(e);
  endtask

  task automatic drain();
    idle(1, 1'b0);
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(posedge CLK);
    @(negedge CLK);
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with live random traffic
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'($urandom), 2'($urandom), 25'($urandom), 25'($urandom),
            18'($urandom), 48'({$urandom, $urandom}), 2'($urandom), 1'($urandom));
      @(negedge CLK);
      check("rst_P", P, 0);
      check("rst_OUT_VALID", OUT_VALID, 0);
      check("rst_flags", {PATTERNDETECT, OVERFLOW, UNDERFLOW}, 3'b000);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0; IN_VALID = 1'b0; CLR_ALL = 1'b0;
    idle(6, 1'b0);

    // Pre-add LOAD then back-to-back ADD on the same channel
    send(2'd2, 2'b01, 25'sd3, 25'sd5, 18'sd4, 48'sd10, 2'b00, 48'sd42, 1'b0, 1'b0, 1'b0);
    send(2'd2, 2'b01, 25'sd3, 25'sd5, 18'sd4, 48'sd0,  2'b01, 48'sd74, 1'b0, 1'b0, 1'b0);
    // Interleaved channels from cleared state
    send(2'd0, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd1, 1'b0, 1'b0, 1'b0);
    send(2'd1, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd1, 1'b0, 1'b0, 1'b0);
    send(2'd0, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd2, 1'b0, 1'b0, 1'b0);
    send(2'd1, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd2, 1'b0, 1'b0, 1'b0);
    // D-A, D-only and CLR modes: (2-7)*3 = -15, -15 + (-4*5) = -35, CLR -> 0
    send(2'd0, 2'b10, 25'sd7, 25'sd2,  18'sd3, 48'sd0,  2'b00, -48'sd15, 1'b0, 1'b0, 1'b0);
    send(2'd0, 2'b11, 25'sd9, -25'sd4, 18'sd5, 48'sd0,  2'b01, -48'sd35, 1'b0, 1'b0, 1'b0);
    send(2'd0, 2'b00, 25'sd1, 25'sd0,  18'sd1, 48'sd99, 2'b11, 48'sd0,   1'b0, 1'b0, 1'b0);
    // Positive overflow and negative underflow
    send(2'd3, 2'b00, 25'sd0, 25'sd0, 18'sd0, MAXP,   2'b00, MAXP, 1'b0, 1'b0, 1'b0);
    send(2'd3, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, OV_P, 1'b0, 1'b1, 1'b0);
    send(2'd3, 2'b00, 25'sd0, 25'sd0, 18'sd0, MINP,   2'b00, MINP, 1'b0, 1'b0, 1'b0);
    send(2'd3, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b10, UF_P, 1'b0, 1'b0, 1'b1);
    // Pattern match with autoreset
    send(2'd2, 2'b00, 25'sd0, 25'sd0, 18'sd0, 48'sd100, 2'b00, 48'sd100, 1'b1, 1'b0, 1'b0);
    send(2'd2, 2'b00, 25'sd5, 25'sd0, 18'sd1, 48'sd0,   2'b01, 48'sd5,   1'b0, 1'b0, 1'b0);
    // CLR_ALL coincident with the S4 result of 7 on CH1
    send(2'd1, 2'b00, 25'sd0, 25'sd0, 18'sd0, 48'sd7, 2'b00, 48'sd7, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    send(2'd1, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd1, 1'b0, 1'b0, 1'b0);
    send(2'd3, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd1, 1'b0, 1'b0, 1'b0);
    send(2'd2, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd1, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset while samples are in flight: they must never emerge
    drive(1'b1, 2'd0, 2'b00, 25'sd3, 25'sd0, 18'sd3, 48'sd0, 2'b01, 1'b0);
    drive(1'b1, 2'd1, 2'b00, 25'sd3, 25'sd0, 18'sd3, 48'sd0, 2'b01, 1'b0);
    @(negedge CLK);
    #2;
    RST = 1'b1; IN_VALID = 1'b0;
    #1;
    check("async_rst_P", P, 0);
    check("async_rst_OUT_VALID", OUT_VALID, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(8, 1'b0);
    send(2'd0, 2'b00, 25'sd1, 25'sd0, 18'sd1, 48'sd0, 2'b01, 48'sd1, 1'b0, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
